instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: accepts symbolic MIPS instructions (mnemonic code plus register, immediate and target fields) over a valid/ready stream.
- Assembles each one into a 32-bit machine word, buffers it in a small FIFO, and writes words sequentially into instruction memory from BASE_ADDR.
- Used by the testbench and boot path to load programs into imem before the single-cycle core is released from reset.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
AW, 32, imem byte-address width
BASE_ADDR, 0, byte address of the first written word (word-aligned)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  pulse: clear address/count/err and return to IDLE (honoured in IDLE or DONE only)
finish  in  1  pulse: no more instructions; drain FIFO, then DONE
in_valid  in  1  instruction valid
in_ready  out  1  block can accept
mnem  in  5  mnemonic code (table below)
rs, rt, rd  in  5 each  register fields
imm  in  16  immediate / offset
target  in  26  jump target field
imem_we  out  1  write request
imem_ready  in  1  memory accepts write this cycle
imem_addr  out  AW  byte address
imem_wdata  out  32  encoded word
count  out  AW  words written since start
err  out  1  sticky: illegal mnemonic seen
done  out  1  load complete

Behaviour:
- Reset: state IDLE, FIFO empty, in_ready=0 until first clk edge after reset release (then 1), imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, err=0, done=0.
- Mnemonic codes and encoding:
  - R-type, {000000,rs,rt,rd,00000,funct}: 0 add 100000; 1 sub 100010; 2 and 100100; 3 or 100101; 4 slt 101010.
  - 5 jr: rt=rd=0, funct 001000.
  - 6 mult: rd=0, funct 011000.
  - I-type, {op,rs,rt,imm}: 7 lw 100011; 8 sw 101011; 9 beq 000100; 10 bne 000101; 11 addi 001000; 12 ori 001101; 13 andi 001100; 14 xori 001110; 15 slti 001010; 16 lh 100001; 17 lb 100000; 18 lbu 100100; 19 sh 101001; 20 sb 101000.
  - 21 lui 001111: rs forced 0.
  - 22 blez 000110: rt forced 0.
  - J-type, {op,target}: 23 j 000010; 24 jal 000011.
  - Codes 25-31 are illegal.
- Unused fields are forced to zero, never passed through.
- States:
  - IDLE -> LOAD on first accept.
  - IDLE -> DONE on finish.
  - LOAD -> DRAIN on finish.
  - DRAIN -> DONE when FIFO empty and no write in flight.
  - DONE -> IDLE on start.
- in_ready = (state IDLE or LOAD) && FIFO not full.
- Accept = in_valid && in_ready. Encoding is combinational; the word is pushed at the accept edge, so earliest imem_we is the next cycle.
- Illegal mnemonic: handshake completes, no push, err set (sticky until start/reset).
- Write side: imem_we = FIFO non-empty (states LOAD/DRAIN). imem_wdata = FIFO head; imem_addr = current address.
  - On imem_we && imem_ready: pop, address += 4 (wraps modulo 2^AW), count += 1.
  - imem_we, imem_addr and imem_wdata hold stable while imem_ready=0.
- Simultaneous push and pop: occupancy unchanged. Push when full is impossible because in_ready=0.
- finish in the same cycle as an accept in LOAD: the word is accepted, then state goes to DRAIN.
- finish in DRAIN/DONE: ignored.
- start in LOAD/DRAIN: ignored.
- done=1 only in DONE.
- Reset mid-load: FIFO contents discarded, imem_we drops immediately (asynchronously).
- Throughput: 1 word/cycle with imem_ready held high. Latency from accept to imem_we is 1 cycle.

Test Plan:
- Encoding:
  - add rs=1 rt=2 rd=3 -> imem_wdata 0x00221820 at addr BASE_ADDR.
  - lw rs=29 rt=8 imm=0x0004 -> 0x8FA80004.
  - jal target=0x0100000 -> 0x0C100000.
- Field forcing: lui rs=5 rt=9 imm=0xABCD -> 0x3C09ABCD; blez rs=4 rt=7 imm=0xFFFE -> 0x1880FFFE.
- Backpressure: 6 back-to-back instructions with imem_ready=0 for 10 cycles.
  - in_ready drops after 4 accepts (DEPTH=4); imem_we/addr/wdata stable.
  - Once imem_ready=1, all 6 words written at addr 0,4,...,20; count=6.
- Illegal/finish:
  - mnem=27 between two legal instructions -> err=1, only 2 words written at addr 0 and 4.
  - finish -> done=1 after the last write.
  - start -> err=0, count=0, addr=BASE_ADDR.
- Wrap: AW=8, BASE_ADDR=0xF8, 3 instructions -> addresses 0xF8, 0xFC, 0x00.
- Reset mid-load: assert reset with 3 words queued -> imem_we=0 same cycle; after release FIFO empty, count=0, state IDLE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: assembles symbolic MIPS instructions into machine words,
// queues them in a small FIFO and writes them sequentially into imem from BASE_ADDR.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, finish       control pulses (restart in IDLE/DONE, end of program)
//   in_valid, in_ready  instruction stream handshake
//   mnem, rs, rt, rd    mnemonic code and register fields
//   imm, target         immediate / offset and jump target fields
//   imem_we, imem_ready imem write request and acceptance
//   imem_addr           byte address of the word being written
//   imem_wdata          encoded word being written
//   count               words written since start
//   err                 sticky illegal-mnemonic flag
//   done                load complete
module instr_encoder_loader #(
    parameter int            DEPTH     = 4,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW-1:0] count,
    output logic          err,
    output logic          done
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    logic        armed;
    logic [31:0] mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;
    logic        enc_ok;

    // Combinational assembler; every field not part of the format is zeroed.
    always_comb begin
        enc_word = 32'h0;
        enc_ok   = 1'b1;
        unique case (mnem)
            5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
            5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
            5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
            5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
            5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
            5'd5:  enc_word = {6'b000000, rs, 15'b0, 6'b001000};
            5'd6:  enc_word = {6'b000000, rs, rt, 10'b0, 6'b011000};
            5'd7:  enc_word = {6'b100011, rs, rt, imm};
            5'd8:  enc_word = {6'b101011, rs, rt, imm};
            5'd9:  enc_word = {6'b000100, rs, rt, imm};
            5'd10: enc_word = {6'b000101, rs, rt, imm};
            5'd11: enc_word = {6'b001000, rs, rt, imm};
            5'd12: enc_word = {6'b001101, rs, rt, imm};
            5'd13: enc_word = {6'b001100, rs, rt, imm};
            5'd14: enc_word = {6'b001110, rs, rt, imm};
            5'd15: enc_word = {6'b001010, rs, rt, imm};
            5'd16: enc_word = {6'b100001, rs, rt, imm};
            5'd17: enc_word = {6'b100000, rs, rt, imm};
            5'd18: enc_word = {6'b100100, rs, rt, imm};
            5'd19: enc_word = {6'b101001, rs, rt, imm};
            5'd20: enc_word = {6'b101000, rs, rt, imm};
            5'd21: enc_word = {6'b001111, 5'b0, rt, imm};
            5'd22: enc_word = {6'b000110, rs, 5'b0, imm};
            5'd23: enc_word = {6'b000010, target};
            5'd24: enc_word = {6'b000011, target};
            default: enc_ok = 1'b0;
        endcase
    end

    // Pointers carry one extra bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // armed keeps in_ready low until the first edge after reset release.
    assign in_ready = armed && !full &&
                      (state == S_IDLE || state == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_ok;

    // Built from async-reset registers, so it falls as soon as reset rises.
    assign imem_we    = !empty && (state == S_LOAD || state == S_DRAIN);
    assign pop        = imem_we && imem_ready;
    assign imem_wdata = imem_we ? mem[rd_ptr[PW-1:0]] : 32'h0;
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            imem_addr <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + (PW+1)'(1);
                imem_addr <= imem_addr + AW'(4);
                count     <= count + AW'(1);
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        imem_addr <= BASE_ADDR;
                        count     <= '0;
                        err       <= 1'b0;
                    end
                    if (finish) begin
                        state <= push ? S_DRAIN : S_DONE;
                    end else if (accept) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (finish) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state     <= S_IDLE;
                        imem_addr <= BASE_ADDR;
                        count     <= '0;
                        err       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // An illegal mnemonic in the same cycle as start still flags.
            if (accept && !enc_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule
